hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Producer-side companion to the EX-stage operand forwarding unit in the 5-stage MIPS pipeline. It detects the hazards that forwarding cannot resolve and drives stall, bubble and flush controls for the IF/ID and ID/EX boundaries.
- Covered hazards: load-use, taken-branch flush, and busy/dependency tracking for a multi-cycle MULT/DIV unit writing HI/LO.
- Sits in the ID stage next to the forwarder. It also maintains a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4, busy cycles for MULT/MULTU after issue (1..63)
- DIV_CYCLES, 32, busy cycles for DIV/DIVU after issue (1..63)
- CNT_W, 6, width of the MULT/DIV countdown register

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- id_is_div  in  1  qualifies id_is_muldiv: DIV/DIVU
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold the IF/ID register
- idex_bubble  out  1  load a NOP into ID/EX
- ifid_flush  out  1  clear IF/ID to a NOP
- md_busy  out  1  MULT/DIV unit busy
- md_done  out  1  single-cycle pulse in the last busy cycle
- stall_cycles  out  16  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0, asynchronous): countdown register = 0, md_busy = 0, md_done = 0, stall_cycles = 0. Combinational outputs follow their equations; with all inputs at 0 every output is 0. An in-flight MULT/DIV is abandoned.
- Load-use: lu = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
  - Purely combinational.
  - The inserted bubble clears ex_mem_read on the next cycle, so the stall lasts exactly 1 cycle.
- MULT/DIV hazard: md_haz = md_busy & (id_is_muldiv | id_reads_hilo).
- stall = lu | md_haz.
- Flush: ex_branch_taken has priority over stall.
  - Taken branch, any stall state: ifid_flush = 1, idex_bubble = 1, pc_stall = 0, ifid_stall = 0.
  - Otherwise: pc_stall = ifid_stall = idex_bubble = stall; ifid_flush = 0.
- Issue: md_issue = id_is_muldiv & ~stall & ~ex_branch_taken. Evaluated each cycle; a flushed or stalled MULT/DIV does not issue.
- Countdown register cnt:
  - On an edge where md_issue = 1, cnt loads DIV_CYCLES if id_is_div, else MULT_CYCLES.
  - Else, if cnt != 0, cnt decrements.
- md_busy = (cnt != 0).
- md_done = (cnt == 1). HI/LO are valid from the cycle after md_done.
- Issue latency:
  - Issue accepted at edge E, so md_busy is high for exactly N cycles after E (N = MULT_CYCLES or DIV_CYCLES).
  - A dependent MFHI/MFLO or MULT/DIV held in ID proceeds in the first cycle with md_busy = 0.
- Non-dependent instructions continue while md_busy = 1 (no stall).
- Issue while busy cannot occur: md_haz blocks it.
- stall_cycles increments on every edge where pc_stall = 1 and saturates at 16'hFFFF. Flush cycles are not counted.
- Register $0 never causes a load-use stall.
- All state changes occur on the rising clk edge only, apart from the asynchronous reset.

Test Plan:
- LW $5 in EX (ex_mem_read=1, ex_rd=5), ADD $6,$5,$7 in ID (id_rs=5, id_uses_rs=1): pc_stall = ifid_stall = idex_bubble = 1 for 1 cycle. Next cycle (ex_mem_read=0) all 0; stall_cycles = 1.
- LW $0 in EX, id_rs=0, id_uses_rs=1: no stall. Same with ex_rd=5, id_rt=5, id_uses_rt=0: no stall.
- MULT issued at edge E, MFLO in ID on the next cycle: md_busy = 1 for exactly 4 cycles; md_done pulses in the 4th; pc_stall = 1 for those 4 cycles; MFLO proceeds in cycle 5; stall_cycles = 4.
- DIV issued, followed by independent ADDs: md_busy = 1 for 32 cycles, pc_stall stays 0, md_done pulses once at cycle 32.
- Load-use stall coincident with ex_branch_taken = 1: ifid_flush = 1, idex_bubble = 1, pc_stall = 0. A MULT in ID at that moment does not issue (md_busy stays 0).
- DIV in progress (cnt=20), rst_n pulsed low mid-cycle: md_busy, md_done and stall_cycles drop to 0 immediately, without waiting for a clock edge. After release, MFHI in ID is not stalled.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard detector for the 5-stage MIPS pipeline.
// Resolves hazards that EX-stage forwarding cannot cover: load-use, taken
// branch/jump flushes and dependencies on the multi-cycle MULT/DIV unit that
// writes HI/LO. It also keeps a saturating count of stalled cycles.
module hazard_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic        id_is_div,
  input  logic        id_reads_hilo,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             lu;
  logic             md_haz;
  logic             stall;
  logic             md_issue;
  logic [CNT_W-1:0] cnt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // Hazard detection: a load feeding the ID instruction (never via $0), or a
  // HI/LO consumer / new MULT/DIV while the unit is still busy.
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    md_haz   = md_busy && (id_is_muldiv || id_reads_hilo);
    stall    = lu || md_haz;
    // A flushed or stalled MULT/DIV must not start the unit.
    md_issue = id_is_muldiv && !stall && !ex_branch_taken;
  end

  // Pipeline control: a taken branch squashes IF/ID and ID/EX and overrides
  // any stall, since the stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      pc_stall    = stall;
      ifid_stall  = stall;
      idex_bubble = stall;
    end
  end

  // Busy flags decode straight from the countdown so reset clears them at once.
  assign md_busy = (cnt != '0);
  assign md_done = (cnt == CNT_ONE);

  // MULT/DIV countdown: load the latency on issue, otherwise run down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (md_issue) begin
      cnt <= id_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Performance counter: counts cycles the PC was held; flush cycles excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
    end else if (pc_stall) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end

endmodule
